// File: rtl/instr_realign_n.sv
// Purpose : splits each fetch block into up to NP compacted RVI/RVC instructions in
//           program order, carrying an instruction's lower half across block boundaries.
// Latency : 1 cycle (registered output bundle); Backpressure: ready_o = !out_valid_q || ready_i,
//           and while the bundle is stalled both the outputs and the carry state hold.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  drops the carry and the output bundle; blocks input this cycle
//   valid_i / ready_o        fetch block handshake (address_i, data_i)
//   valid_o / ready_i        output bundle handshake (addr_o, instr_o per slot)
//   serving_unaligned_o      carry register currently holds a lower half

package config_pkg;
    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd64};
endpackage

module instr_realign_n #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
    parameter int unsigned           FETCH_WIDTH = 64
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    input  logic [CVA6Cfg.VLEN-1:0]                       address_i,
    input  logic [FETCH_WIDTH-1:0]                        data_i,
    input  logic                                          ready_i,
    output logic [FETCH_WIDTH/16-1:0]                     valid_o,
    output logic [FETCH_WIDTH/16-1:0][CVA6Cfg.VLEN-1:0]   addr_o,
    output logic [FETCH_WIDTH/16-1:0][31:0]               instr_o,
    output logic                                          serving_unaligned_o
);

    localparam int unsigned VLEN = CVA6Cfg.VLEN;
    localparam int unsigned NP   = FETCH_WIDTH / 16;
    localparam int unsigned OFFW = $clog2(FETCH_WIDTH / 8);  // byte-offset bits within a block
    localparam int unsigned SW   = OFFW - 1;                 // parcel-index bits

    if (!(FETCH_WIDTH == 32 || FETCH_WIDTH == 64 || FETCH_WIDTH == 128)) begin : g_bad_fetch_width
        $error("instr_realign_n: FETCH_WIDTH must be 32, 64 or 128");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                          out_valid_q;
    logic [NP-1:0]                 valid_q;
    logic [NP-1:0][VLEN-1:0]       addr_q;
    logic [NP-1:0][31:0]           instr_q;
    logic                          unaligned_q;
    logic [15:0]                   unaligned_instr_q;
    logic [VLEN-1:0]               unaligned_address_q;

    // ------------------------------------------------------------------
    // Scan of the incoming block
    // ------------------------------------------------------------------
    logic [SW-1:0]                 start_parcel;
    logic [VLEN-OFFW-1:0]          blk_hi;
    logic [FETCH_WIDTH+15:0]       data_ext;
    logic                          carry_hit;

    logic [NP-1:0]                 slot_vld_d;
    logic [NP-1:0][VLEN-1:0]       slot_addr_d;
    logic [NP-1:0][31:0]           slot_instr_d;
    logic                          unaligned_d;
    logic [15:0]                   unaligned_instr_d;
    logic [VLEN-1:0]               unaligned_address_d;

    assign start_parcel = address_i[OFFW-1:1];
    assign blk_hi       = address_i[VLEN-1:OFFW];
    // Zero pad on top so the "upper half" select of the last parcel stays in range;
    // that value is never used because the last parcel can only start a carry.
    assign data_ext     = {16'h0000, data_i};
    assign carry_hit    = unaligned_q && (address_i == unaligned_address_q + VLEN'(2));

    always_comb begin : scan
        logic [SW:0]   cnt;
        logic          skip;
        logic [SW-1:0] pi;
        logic [15:0]   lo;
        logic [15:0]   hi;

        slot_vld_d          = '0;
        slot_addr_d         = '0;
        slot_instr_d        = '0;
        unaligned_d         = 1'b0;
        unaligned_instr_d   = unaligned_instr_q;
        unaligned_address_d = unaligned_address_q;
        cnt                 = '0;
        skip                = 1'b0;
        pi                  = '0;
        lo                  = '0;
        hi                  = '0;

        for (int p = 0; p < int'(NP); p++) begin
            pi = SW'(p);
            lo = data_ext[16*p +: 16];
            hi = data_ext[16*(p+1) +: 16];
            if (pi >= start_parcel) begin
                if (carry_hit && (pi == start_parcel)) begin
                    // First wanted parcel is the upper half of the carried instruction.
                    slot_vld_d[cnt[SW-1:0]]   = 1'b1;
                    slot_addr_d[cnt[SW-1:0]]  = unaligned_address_q;
                    slot_instr_d[cnt[SW-1:0]] = {lo, unaligned_instr_q};
                    cnt                       = cnt + 1'b1;
                end else if (skip) begin
                    // Upper half of a 32-bit instruction already emitted.
                    skip = 1'b0;
                end else if (lo[1:0] != 2'b11) begin
                    slot_vld_d[cnt[SW-1:0]]   = 1'b1;
                    slot_addr_d[cnt[SW-1:0]]  = {blk_hi, pi, 1'b0};
                    slot_instr_d[cnt[SW-1:0]] = {16'h0000, lo};
                    cnt                       = cnt + 1'b1;
                end else if (pi == SW'(NP - 1)) begin
                    // 32-bit instruction straddles into the next block.
                    unaligned_d         = 1'b1;
                    unaligned_instr_d   = lo;
                    unaligned_address_d = {blk_hi, pi, 1'b0};
                end else begin
                    slot_vld_d[cnt[SW-1:0]]   = 1'b1;
                    slot_addr_d[cnt[SW-1:0]]  = {blk_hi, pi, 1'b0};
                    slot_instr_d[cnt[SW-1:0]] = {hi, lo};
                    cnt                       = cnt + 1'b1;
                    skip                      = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake and output / carry registers
    // ------------------------------------------------------------------
    logic accept;

    assign ready_o = (!out_valid_q || ready_i) && !flush_i;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q         <= 1'b0;
            valid_q             <= '0;
            addr_q              <= '0;
            instr_q             <= '0;
            unaligned_q         <= 1'b0;
            unaligned_instr_q   <= '0;
            unaligned_address_q <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
            valid_q     <= '0;
            unaligned_q <= 1'b0;
        end else if (accept) begin
            // A block that yields no slot still updates the carry.
            out_valid_q         <= |slot_vld_d;
            valid_q             <= slot_vld_d;
            addr_q              <= slot_addr_d;
            instr_q             <= slot_instr_d;
            unaligned_q         <= unaligned_d;
            unaligned_instr_q   <= unaligned_instr_d;
            unaligned_address_q <= unaligned_address_d;
        end else if (ready_i) begin
            // Bundle consumed with nothing new behind it.
            out_valid_q <= 1'b0;
            valid_q     <= '0;
        end
    end

    assign valid_o             = valid_q;
    assign addr_o              = addr_q;
    assign instr_o             = instr_q;
    assign serving_unaligned_o = unaligned_q;

endmodule

// File: tb/tb_instr_realign_n.sv
module tb_instr_realign_n;

    typedef struct packed {
        logic [7:0]        vld;
        logic [7:0][63:0]  addr;
        logic [7:0][31:0]  instr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus per DUT
    logic         v32 = 0, v64 = 0, v128 = 0;
    logic         r32 = 1, r64 = 1, r128 = 1;
    logic [63:0]  a32 = '0, a64 = '0, a128 = '0;
    logic [31:0]  d32 = '0;
    logic [63:0]  d64 = '0;
    logic [127:0] d128 = '0;

    // Outputs per DUT
    logic              rdy32, rdy64, rdy128;
    logic [1:0]        vo32;
    logic [3:0]        vo64;
    logic [7:0]        vo128;
    logic [1:0][63:0]  ao32;
    logic [3:0][63:0]  ao64;
    logic [7:0][63:0]  ao128;
    logic [1:0][31:0]  io32;
    logic [3:0][31:0]  io64;
    logic [7:0][31:0]  io128;
    logic              su32, su64, su128;

    instr_realign_n #(.FETCH_WIDTH(32)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(v32), .ready_o(rdy32),
        .address_i(a32), .data_i(d32), .ready_i(r32), .valid_o(vo32), .addr_o(ao32),
        .instr_o(io32), .serving_unaligned_o(su32));

    instr_realign_n #(.FETCH_WIDTH(64)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(v64), .ready_o(rdy64),
        .address_i(a64), .data_i(d64), .ready_i(r64), .valid_o(vo64), .addr_o(ao64),
        .instr_o(io64), .serving_unaligned_o(su64));

    instr_realign_n #(.FETCH_WIDTH(128)) u128 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(v128), .ready_o(rdy128),
        .address_i(a128), .data_i(d128), .ready_i(r128), .valid_o(vo128), .addr_o(ao128),
        .instr_o(io128), .serving_unaligned_o(su128));

    // Zero-padded views so one compare routine serves all widths
    logic [7:0]       vo32p, vo64p;
    logic [7:0][63:0] ao32p, ao64p;
    logic [7:0][31:0] io32p, io64p;
    assign vo32p = 8'(vo32);
    assign vo64p = 8'(vo64);
    assign ao32p = 512'(ao32);
    assign ao64p = 512'(ao64);
    assign io32p = 256'(io32);
    assign io64p = 256'(io64);

    exp_t q32[$], q64[$], q128[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic cmp(input string nm, input exp_t e, input logic [7:0] v,
                       input logic [7:0][63:0] a, input logic [7:0][31:0] i);
        chk({nm, ".valid"}, 64'(v), 64'(e.vld));
        for (int k = 0; k < 8; k++) begin
            if (e.vld[k]) begin
                chk($sformatf("%s.addr%0d", nm, k), a[k], e.addr[k]);
                chk($sformatf("%s.instr%0d", nm, k), 64'(i[k]), 64'(e.instr[k]));
            end
        end
    endtask

    function automatic exp_t mk_seq(input int n, input logic [63:0] base, input logic [31:0] ins);
        exp_t e;
        e = '0;
        for (int k = 0; k < n; k++) begin
            e.vld[k]   = 1'b1;
            e.addr[k]  = base + 64'(2 * k);
            e.instr[k] = ins;
        end
        return e;
    endfunction

    // Monitors: a bundle is consumed at the edge following a negedge where it is
    // presented with ready_i high, so each bundle is popped exactly once.
    exp_t e32, e64, e128;
    always @(negedge clk) begin
        if (rst_n && vo32 != '0 && r32) begin
            if (q32.size() == 0) chk("sb32.unexpected_bundle", 64'(q32.size()), 64'd1);
            else begin e32 = q32.pop_front(); cmp("sb32", e32, vo32p, ao32p, io32p); end
        end
    end
    always @(negedge clk) begin
        if (rst_n && vo64 != '0 && r64) begin
            if (q64.size() == 0) chk("sb64.unexpected_bundle", 64'(q64.size()), 64'd1);
            else begin e64 = q64.pop_front(); cmp("sb64", e64, vo64p, ao64p, io64p); end
        end
    end
    always @(negedge clk) begin
        if (rst_n && vo128 != '0 && r128) begin
            if (q128.size() == 0) chk("sb128.unexpected_bundle", 64'(q128.size()), 64'd1);
            else begin e128 = q128.pop_front(); cmp("sb128", e128, vo128, ao128, io128); end
        end
    end

    function automatic logic rdy(input int w);
        case (w)
            32:      return rdy32;
            64:      return rdy64;
            default: return rdy128;
        endcase
    endfunction

    task automatic drive(input int w, input logic [63:0] a, input logic [127:0] d);
        case (w)
            32:      begin v32 = 1'b1;  a32 = a;  d32 = d[31:0];  end
            64:      begin v64 = 1'b1;  a64 = a;  d64 = d[63:0];  end
            default: begin v128 = 1'b1; a128 = a; d128 = d;       end
        endcase
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int w, input logic [63:0] a, input logic [127:0] d);
        int n;
        drive(w, a, d);
        n = 0;
        @(negedge clk);
        while (!rdy(w) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            $display("FAIL send_timeout: ready_o low for %0d cycles, expected accept", n);
        end
        @(posedge clk);
        #1;
        v32 = 1'b0; v64 = 1'b0; v128 = 1'b0;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] RVC8 = 128'h0001_0001_0001_0001_0001_0001_0001_0001;
    localparam logic [127:0] I_C_U = 128'h0003_0001_0000_0013;

    exp_t e;

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("reset.valid_o", 64'(vo64), 64'd0);
        chk("reset.addr_o0", ao64[0], 64'd0);
        chk("reset.instr_o0", 64'(io64[0]), 64'd0);
        chk("reset.serving", 64'(su64), 64'd0);
        chk("reset.ready_o", 64'(rdy64), 64'd1);
        sync();
        rst_n = 1'b1;

        // Four RVC
        q64.push_back(mk_seq(4, 64'h1000, 32'h0001));
        send(64, 64'h1000, RVC8);

        // I, C, then uncompressed last parcel -> carry at 0x1006
        e = '0;
        e.vld = 8'b0011;
        e.addr[0] = 64'h1000; e.instr[0] = 32'h0000_0013;
        e.addr[1] = 64'h1004; e.instr[1] = 32'h0000_0001;
        q64.push_back(e);
        send(64, 64'h1000, I_C_U);
        @(negedge clk);
        chk("carry.serving_set", 64'(su64), 64'd1);
        sync();

        // Next block completes the carry
        e = '0;
        e.vld = 8'b0111;
        e.addr[0] = 64'h1006; e.instr[0] = 32'h0000_0003;
        e.addr[1] = 64'h100A; e.instr[1] = 32'h0000_0001;
        e.addr[2] = 64'h100C; e.instr[2] = 32'h0002_0013;
        q64.push_back(e);
        send(64, 64'h1008, 128'h0002_0013_0001_0000);
        @(negedge clk);
        chk("carry.serving_clear", 64'(su64), 64'd0);
        sync();

        // s = NP-1 with uncompressed parcel: no slots, carry at 0x100E
        send(64, 64'h100E, 128'h0013_0001_0001_0001);
        @(negedge clk);
        chk("lastparcel.valid_o", 64'(vo64), 64'd0);
        chk("lastparcel.ready_o", 64'(rdy64), 64'd1);
        chk("lastparcel.serving", 64'(su64), 64'd1);
        sync();
        e = mk_seq(4, 64'h100E, 32'h0000_0001);
        e.instr[0] = 32'h0000_0013;
        e.addr[1]  = 64'h1012; e.addr[2] = 64'h1014; e.addr[3] = 64'h1016;
        q64.push_back(e);
        send(64, 64'h1010, 128'h0001_0001_0001_0000);

        // Redirect drops the carry
        e = '0;
        e.vld = 8'b0011;
        e.addr[0] = 64'h1000; e.instr[0] = 32'h0000_0013;
        e.addr[1] = 64'h1004; e.instr[1] = 32'h0000_0001;
        q64.push_back(e);
        send(64, 64'h1000, I_C_U);
        q64.push_back(mk_seq(4, 64'h2000, 32'h0001));
        send(64, 64'h2000, RVC8);
        @(negedge clk);
        chk("redirect.serving", 64'(su64), 64'd0);
        sync();

        // Three stall cycles with the next block held
        r64 = 1'b0;
        q64.push_back(mk_seq(4, 64'h3000, 32'h0001));
        send(64, 64'h3000, RVC8);
        e = mk_seq(4, 64'h3008, 32'h0);
        e.instr[0] = 32'h0005; e.instr[1] = 32'h0009; e.instr[2] = 32'h000D; e.instr[3] = 32'h0011;
        q64.push_back(e);
        drive(64, 64'h3008, 128'h0011_000D_0009_0005);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.ready_o", c), 64'(rdy64), 64'd0);
            chk($sformatf("stall%0d.valid_o", c), 64'(vo64), 64'hF);
            chk($sformatf("stall%0d.addr_o0", c), ao64[0], 64'h3000);
        end
        sync();
        r64 = 1'b1;
        send(64, 64'h3008, 128'h0011_000D_0009_0005);
        sync();

        // Flush while stalled with carry set
        r64 = 1'b0;
        send(64, 64'h4000, I_C_U);
        flush = 1'b1;
        @(negedge clk);
        chk("flush.ready_o_low", 64'(rdy64), 64'd0);
        chk("flush.serving_before", 64'(su64), 64'd1);
        sync();
        flush = 1'b0;
        r64 = 1'b1;
        @(negedge clk);
        chk("flush.valid_o", 64'(vo64), 64'd0);
        chk("flush.serving", 64'(su64), 64'd0);
        chk("flush.ready_o", 64'(rdy64), 64'd1);
        sync();
        q64.push_back(mk_seq(4, 64'h4008, 32'h0001));
        send(64, 64'h4008, RVC8);

        // Other fetch widths
        q32.push_back(mk_seq(2, 64'h1000, 32'h0001));
        send(32, 64'h1000, RVC8);
        q128.push_back(mk_seq(8, 64'h1000, 32'h0001));
        send(128, 64'h1000, RVC8);
        sync();

        // Asynchronous reset mid-stall
        r64 = 1'b0;
        send(64, 64'h5000, RVC8);
        @(negedge clk);
        chk("rststall.valid_before", 64'(vo64), 64'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("rststall.valid_o", 64'(vo64), 64'd0);
        chk("rststall.ready_o", 64'(rdy64), 64'd1);
        sync();
        rst_n = 1'b1;
        r64 = 1'b1;

        repeat (4) @(negedge clk);
        chk("sb32.drained", 64'(q32.size()), 64'd0);
        chk("sb64.drained", 64'(q64.size()), 64'd0);
        chk("sb128.drained", 64'(q128.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
